// File: rtl/spi_pkg.sv
// Shared types and edge-select helpers for the oversampled SPI slave.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    // Data is sampled on the rising spi_clk edge when CPOL equals CPHA, otherwise on the falling edge.
    function automatic logic sample_edge_sel(input logic cpol, input logic cpha);
        return (cpol == cpha) ? EDGE_RISE : EDGE_FALL;
    endfunction

endpackage

// File: rtl/sync_bits.sv
// Multi-bit flop synchronizer with a per-bit reset level.
module sync_bits #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the asynchronous inputs through the synchronizer chain.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/spi_slave_oversampled.sv
// SPI slave that oversamples the SPI pins with clk_sys.
//
// state  | meaning
// IDLE   | chip select high, spi_clk edges ignored
// ACTIVE | chip select low, shifting words in and out
module spi_slave_oversampled
    import spi_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter bit                CPOL        = 1'b0,
    parameter bit                CPHA        = 1'b0,
    parameter bit                MSB_FIRST   = 1'b1,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE     = '1
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int              CNT_W       = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam int              FL_W        = $clog2(SYNC_STAGES + 1);
    localparam logic            SAMPLE_RISE = sample_edge_sel(CPOL, CPHA);

    logic [2:0]        pins_s;
    logic              s_clk, s_cs_n, s_mosi;
    logic              clk_d, cs_n_d, mosi_d;
    logic              samp_stb, shift_stb;
    logic [FL_W-1:0]   flush_cnt;
    logic              armed;
    logic              cs_fall, cs_rise;
    spi_state_t        state, state_nx;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_sh, rx_next;
    logic [DATA_W-1:0] tx_sh, tx_buf, tx_load_val;
    logic              tx_full;
    logic              skip_shift;
    logic              pend_und;

    sync_bits #(
        .WIDTH   (3),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ({CPOL, 1'b1, 1'b0})
    ) u_sync (
        .clk_sys (clk_sys),
        .rst     (rst),
        .d       ({spi_clk, spi_cs_n, spi_mosi}),
        .q       (pins_s)
    );

    assign s_clk  = pins_s[2];
    assign s_cs_n = pins_s[1];
    assign s_mosi = pins_s[0];

    // Delayed copies of the synced pins and registered spi_clk edge strobes; MOSI is delayed to line up with the strobe.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            clk_d     <= CPOL;
            cs_n_d    <= 1'b1;
            mosi_d    <= 1'b0;
            samp_stb  <= 1'b0;
            shift_stb <= 1'b0;
        end else begin
            clk_d     <= s_clk;
            cs_n_d    <= s_cs_n;
            mosi_d    <= s_mosi;
            samp_stb  <= SAMPLE_RISE ? (s_clk & ~clk_d) : (~s_clk & clk_d);
            shift_stb <= SAMPLE_RISE ? (~s_clk & clk_d) : (s_clk & ~clk_d);
        end
    end

    // Arm only once the flushed synchronizer has seen chip select high, so a cs_n held low through reset cannot start a word.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            flush_cnt <= FL_W'(SYNC_STAGES);
            armed     <= 1'b0;
        end else begin
            if (flush_cnt != '0) flush_cnt <= flush_cnt - FL_W'(1);
            if (flush_cnt == '0 && s_cs_n && cs_n_d) armed <= 1'b1;
        end
    end

    assign cs_fall = armed & cs_n_d & ~s_cs_n;
    assign cs_rise = ~cs_n_d & s_cs_n;

    // State register.
    always_ff @(posedge clk_sys) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode from chip select edges.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cs_fall) state_nx = ACTIVE;
            ACTIVE:  if (cs_rise) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign rx_next     = MSB_FIRST ? {rx_sh[DATA_W-2:0], mosi_d} : {mosi_d, rx_sh[DATA_W-1:1]};
    assign tx_load_val = tx_full ? tx_buf : TX_IDLE;

    // Word datapath: RX assembly and handshake, TX buffer and shifter, bit counter.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            bit_cnt     <= '0;
            rx_sh       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_sh       <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_underrun <= 1'b0;
            skip_shift  <= 1'b0;
            pend_und    <= 1'b0;
        end else begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
            if (state == IDLE) begin
                if (cs_fall) begin
                    bit_cnt    <= '0;
                    tx_sh      <= tx_load_val;
                    skip_shift <= CPHA;
                    pend_und   <= 1'b0;
                    if (tx_full) tx_full     <= 1'b0;
                    else         tx_underrun <= 1'b1;
                end
            end else if (cs_rise) begin
                bit_cnt    <= '0;
                skip_shift <= 1'b0;
                pend_und   <= 1'b0;
            end else if (samp_stb) begin
                rx_sh <= rx_next;
                // A back-to-back word that was preloaded with TX_IDLE reports its underrun once it actually starts.
                if (pend_und && bit_cnt == '0) begin
                    tx_underrun <= 1'b1;
                    pend_und    <= 1'b0;
                end
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt  <= '0;
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    if (rx_valid && !rx_ready) rx_overrun <= 1'b1;
                    // The trailing shift edge of the finished word must not advance the freshly loaded word.
                    tx_sh      <= tx_load_val;
                    skip_shift <= 1'b1;
                    pend_und   <= !tx_full;
                    if (tx_full) tx_full <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else if (shift_stb) begin
                if (skip_shift) skip_shift <= 1'b0;
                else            tx_sh      <= MSB_FIRST ? (tx_sh << 1) : (tx_sh >> 1);
            end
        end
    end

    assign spi_miso    = MSB_FIRST ? tx_sh[DATA_W-1] : tx_sh[0];
    assign spi_miso_oe = ~s_cs_n;
    assign tx_ready    = ~tx_full;
    assign busy        = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_oversampled.sv
// Directed bench: four slaves (mode 0, mode 1, mode 2, mode 3 LSB-first) driven by a behavioural master.
module tb_spi_slave_oversampled;

    localparam int         H      = 8;
    localparam logic [3:0] CPOL_V = 4'b1100;
    localparam logic [3:0] CPHA_V = 4'b1010;
    localparam logic [3:0] MSB_V  = 4'b0111;

    logic        clk_sys = 1'b0;
    logic        rst     = 1'b1;
    logic [3:0]  sck     = 4'b1100;
    logic [3:0]  csn     = 4'hF;
    logic [3:0]  mosi    = 4'h0;
    logic [3:0]  rxr     = 4'h0;
    logic [3:0]  txv     = 4'h0;
    logic [31:0] txd_all = '0;
    wire  [3:0]  miso, oe, rxv, ovr, txr, und, bsy;
    wire  [31:0] rxd_all;

    int checks = 0;
    int errors = 0;
    int ovr_cnt  [4] = '{default: 0};
    int und_cnt  [4] = '{default: 0};
    int rxv_rise [4] = '{default: 0};
    logic [3:0] rxv_q = 4'h0;

    always #5 clk_sys = ~clk_sys;

    spi_slave_oversampled u0 (
        .clk_sys(clk_sys), .rst(rst), .spi_clk(sck[0]), .spi_cs_n(csn[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso[0]), .spi_miso_oe(oe[0]), .rx_data(rxd_all[7:0]), .rx_valid(rxv[0]),
        .rx_ready(rxr[0]), .rx_overrun(ovr[0]), .tx_data(txd_all[7:0]), .tx_valid(txv[0]),
        .tx_ready(txr[0]), .tx_underrun(und[0]), .busy(bsy[0]));

    spi_slave_oversampled #(.CPHA(1'b1)) u1 (
        .clk_sys(clk_sys), .rst(rst), .spi_clk(sck[1]), .spi_cs_n(csn[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso[1]), .spi_miso_oe(oe[1]), .rx_data(rxd_all[15:8]), .rx_valid(rxv[1]),
        .rx_ready(rxr[1]), .rx_overrun(ovr[1]), .tx_data(txd_all[15:8]), .tx_valid(txv[1]),
        .tx_ready(txr[1]), .tx_underrun(und[1]), .busy(bsy[1]));

    spi_slave_oversampled #(.CPOL(1'b1)) u2 (
        .clk_sys(clk_sys), .rst(rst), .spi_clk(sck[2]), .spi_cs_n(csn[2]), .spi_mosi(mosi[2]),
        .spi_miso(miso[2]), .spi_miso_oe(oe[2]), .rx_data(rxd_all[23:16]), .rx_valid(rxv[2]),
        .rx_ready(rxr[2]), .rx_overrun(ovr[2]), .tx_data(txd_all[23:16]), .tx_valid(txv[2]),
        .tx_ready(txr[2]), .tx_underrun(und[2]), .busy(bsy[2]));

    spi_slave_oversampled #(.CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u3 (
        .clk_sys(clk_sys), .rst(rst), .spi_clk(sck[3]), .spi_cs_n(csn[3]), .spi_mosi(mosi[3]),
        .spi_miso(miso[3]), .spi_miso_oe(oe[3]), .rx_data(rxd_all[31:24]), .rx_valid(rxv[3]),
        .rx_ready(rxr[3]), .rx_overrun(ovr[3]), .tx_data(txd_all[31:24]), .tx_valid(txv[3]),
        .tx_ready(txr[3]), .tx_underrun(und[3]), .busy(bsy[3]));

    // Pulse and rising-edge counters per slave.
    always @(posedge clk_sys) begin
        for (int i = 0; i < 4; i++) begin
            if (ovr[i]) ovr_cnt[i]++;
            if (und[i]) und_cnt[i]++;
            if (rxv[i] && !rxv_q[i]) rxv_rise[i]++;
            rxv_q[i] = rxv[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic load_tx(input int m, input logic [7:0] val);
        txd_all[8*m +: 8] = val;
        txv[m] = 1'b1;
        tick(1);
        txv[m] = 1'b0;
    endtask

    task automatic ack(input int m);
        rxr[m] = 1'b1;
        tick(1);
        rxr[m] = 1'b0;
    endtask

    task automatic cs_start(input int m);
        sck[m] = CPOL_V[m];
        csn[m] = 1'b0;
        tick(H);
    endtask

    task automatic cs_end(input int m);
        tick(H);
        csn[m] = 1'b1;
        tick(2*H);
    endtask

    // Master shifting nbits of w; MISO bits are collected at the master sample edge.
    task automatic xfer_bits(input int m, input logic [7:0] w, input int nbits, input bit lat_chk,
                             output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            int bi;
            bi = MSB_V[m] ? 7 - i : i;
            if (!CPHA_V[m]) begin
                mosi[m] = w[bi];
                tick(H);
                sck[m]  = ~CPOL_V[m];
                got[bi] = miso[m];
                if (lat_chk && i == nbits - 1) begin
                    tick(3);
                    check("latency_early", 32'(rxv[m]), 32'd0);
                    tick(1);
                    check("latency_on", 32'(rxv[m]), 32'd1);
                    tick(H - 4);
                end else begin
                    tick(H);
                end
                sck[m] = CPOL_V[m];
            end else begin
                sck[m]  = ~CPOL_V[m];
                mosi[m] = w[bi];
                tick(H);
                sck[m]  = CPOL_V[m];
                got[bi] = miso[m];
                tick(H);
            end
        end
    endtask

    task automatic word(input int m, input logic [7:0] w, output logic [7:0] got);
        cs_start(m);
        xfer_bits(m, w, 8, 1'b0, got);
        cs_end(m);
    endtask

    initial begin
        logic [7:0] got, got2;
        logic [7:0] tx_vals [4];
        int base_ovr, base_und, base_rxv;
        tx_vals = '{8'h00, 8'h5A, 8'hC3, 8'h96};

        // Reset values
        tick(5);
        check("rst_rx_valid",   32'(rxv[0]), 32'd0);
        check("rst_rx_data",    32'(rxd_all[7:0]), 32'd0);
        check("rst_tx_ready",   32'(txr[0]), 32'd1);
        check("rst_busy",       32'(bsy[0]), 32'd0);
        check("rst_miso",       32'(miso[0]), 32'd0);
        check("rst_miso_oe",    32'(oe[0]), 32'd0);
        check("rst_overrun",    32'(ovr[0]), 32'd0);
        check("rst_underrun",   32'(und[0]), 32'd0);
        check("rst_miso_cpol1", 32'(miso[2]), 32'd0);
        rst = 1'b0;
        tick(10);

        // Mode 0: send 0xA5 with 0x3C loaded
        load_tx(0, 8'h3C);
        check("tx_ready_after_load", 32'(txr[0]), 32'd0);
        base_und = und_cnt[0];
        base_rxv = rxv_rise[0];
        cs_start(0);
        check("busy_active", 32'(bsy[0]), 32'd1);
        check("oe_active", 32'(oe[0]), 32'd1);
        check("tx_ready_consumed", 32'(txr[0]), 32'd1);
        xfer_bits(0, 8'hA5, 8, 1'b1, got);
        cs_end(0);
        check("m0_rx_data", 32'(rxd_all[7:0]), 32'hA5);
        check("m0_miso_word", 32'(got), 32'h3C);
        check("m0_rx_valid_pulses", 32'(rxv_rise[0] - base_rxv), 32'd1);
        check("m0_no_underrun", 32'(und_cnt[0] - base_und), 32'd0);
        check("m0_idle_busy", 32'(bsy[0]), 32'd0);
        ack(0);
        check("m0_rx_valid_acked", 32'(rxv[0]), 32'd0);

        // Modes 1, 2 and 3 (LSB first): send 0x81
        for (int m = 1; m < 4; m++) begin
            load_tx(m, tx_vals[m]);
            word(m, 8'h81, got);
            check($sformatf("mode%0d_rx_data", m), 32'(rxd_all[8*m +: 8]), 32'h81);
            check($sformatf("mode%0d_miso_word", m), 32'(got), 32'(tx_vals[m]));
        end

        // Back-to-back 0x11, 0x22 with rx_ready low
        base_ovr = ovr_cnt[0];
        cs_start(0);
        xfer_bits(0, 8'h11, 8, 1'b0, got);
        xfer_bits(0, 8'h22, 8, 1'b0, got2);
        cs_end(0);
        check("b2b_rx_data", 32'(rxd_all[7:0]), 32'h22);
        check("b2b_rx_valid", 32'(rxv[0]), 32'd1);
        check("b2b_overrun_pulses", 32'(ovr_cnt[0] - base_ovr), 32'd1);
        check("b2b_second_miso", 32'(got2), 32'hFF);
        ack(0);

        // No TX load: idle pattern and one underrun
        base_und = und_cnt[0];
        word(0, 8'h00, got);
        check("und_miso_word", 32'(got), 32'hFF);
        check("und_pulses", 32'(und_cnt[0] - base_und), 32'd1);
        check("und_tx_ready", 32'(txr[0]), 32'd1);
        check("und_rx_data", 32'(rxd_all[7:0]), 32'h00);
        ack(0);

        // Partial word of 5 bits, then full 0x7E
        base_rxv = rxv_rise[0];
        cs_start(0);
        xfer_bits(0, 8'hFF, 5, 1'b0, got);
        cs_end(0);
        check("partial_no_valid", 32'(rxv[0]), 32'd0);
        check("partial_idle", 32'(bsy[0]), 32'd0);
        word(0, 8'h7E, got);
        check("partial_valid_pulses", 32'(rxv_rise[0] - base_rxv), 32'd1);
        check("partial_rx_data", 32'(rxd_all[7:0]), 32'h7E);

        // Reset after 4 bits with rx_valid still high
        cs_start(0);
        xfer_bits(0, 8'hF0, 4, 1'b0, got);
        rst = 1'b1;
        tick(1);
        check("midrst_busy", 32'(bsy[0]), 32'd0);
        check("midrst_rx_valid", 32'(rxv[0]), 32'd0);
        check("midrst_rx_data", 32'(rxd_all[7:0]), 32'd0);
        check("midrst_tx_ready", 32'(txr[0]), 32'd1);
        check("midrst_miso", 32'(miso[0]), 32'd0);
        check("midrst_miso_oe", 32'(oe[0]), 32'd0);
        rst = 1'b0;
        sck[0] = CPOL_V[0];
        tick(H);
        xfer_bits(0, 8'hFF, 8, 1'b0, got);
        tick(H);
        check("postrst_no_start", 32'(bsy[0]), 32'd0);
        check("postrst_no_valid", 32'(rxv[0]), 32'd0);
        csn[0] = 1'b1;
        tick(2*H);
        load_tx(0, 8'hC3);
        word(0, 8'h3C, got);
        check("postrst_rx_data", 32'(rxd_all[7:0]), 32'h3C);
        check("postrst_rx_valid", 32'(rxv[0]), 32'd1);
        check("postrst_miso_word", 32'(got), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
